// File: rtl/flip_patch_ctrl.sv
// Fault-map consumer: scans the 2-bit per-word classification once, then serves
// user accesses with flipped storage for flip-class words and spare registers for patch-class words.
module flip_patch_ctrl #(
    parameter int N_WORDS  = 64,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = $clog2(N_WORDS),
    parameter int N_SPARES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [ADDR_W-1:0]             err_addr,
    input  logic [1:0]                    err_data,
    output logic                          map_done,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic                          mem_write_enable,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(N_SPARES+1)-1:0] spares_used,
    output logic                          overflow
);
    localparam int SU_W  = $clog2(N_SPARES + 1);
    localparam int SP_IW = (N_SPARES > 1) ? $clog2(N_SPARES) : 1;
    localparam logic [SU_W-1:0]   SPARE_MAX = SU_W'(N_SPARES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_READY, S_ACCESS} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0]   scan_addr;
    logic [N_WORDS-1:0]  flip_map;
    logic [N_WORDS-1:0]  unrep_map;
    logic [N_SPARES-1:0] spare_valid;
    logic [ADDR_W-1:0]   spare_addr [N_SPARES];
    logic [DATA_W-1:0]   spare_data [N_SPARES];

    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                hit;
    logic [SP_IW-1:0]    hit_idx;
    logic                in_access;
    logic [DATA_W-1:0]   rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_SCAN;
            S_SCAN:   if (scan_addr == LAST_ADDR) state_d = S_READY;
            S_READY:  if (req_valid) state_d = S_ACCESS;
            S_ACCESS: state_d = S_READY;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < N_SPARES; i++) begin
            if (spare_valid[i] && (spare_addr[i] == lat_addr)) begin
                hit     = 1'b1;
                hit_idx = SP_IW'(i);
            end
        end
    end

    // Unrepairable words go straight to RAM: they never carry a flip bit or a spare.
    always_comb begin
        in_access        = (state_q == S_ACCESS);
        err_addr         = (state_q == S_SCAN) ? scan_addr : '0;
        req_ready        = (state_q == S_READY);
        mem_addr         = in_access ? lat_addr : '0;
        mem_write_enable = in_access && lat_we && !hit;
        mem_wdata        = '0;
        if (mem_write_enable)
            mem_wdata = flip_map[lat_addr] ? ~lat_wdata : lat_wdata;
        if (hit)
            rd_data = spare_data[hit_idx];
        else if (flip_map[lat_addr])
            rd_data = ~mem_rdata;
        else
            rd_data = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_addr   <= '0;
            flip_map    <= '0;
            unrep_map   <= '0;
            spare_valid <= '0;
            spares_used <= '0;
            overflow    <= 1'b0;
            map_done    <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            for (int unsigned i = 0; i < N_SPARES; i++) begin
                spare_addr[i] <= '0;
                spare_data[i] <= '0;
            end
        end else begin
            resp_valid <= (state_q == S_ACCESS);
            case (state_q)
                S_SCAN: begin
                    if (err_data == 2'b01) begin
                        flip_map[scan_addr] <= 1'b1;
                    end else if (err_data[1]) begin
                        if (spares_used < SPARE_MAX) begin
                            spare_valid[spares_used[SP_IW-1:0]] <= 1'b1;
                            spare_addr[spares_used[SP_IW-1:0]]  <= scan_addr;
                            spare_data[spares_used[SP_IW-1:0]]  <= '0;
                            spares_used <= spares_used + 1'b1;
                        end else begin
                            unrep_map[scan_addr] <= 1'b1;
                            overflow             <= 1'b1;
                        end
                    end
                    if (scan_addr == LAST_ADDR) begin
                        scan_addr <= '0;
                        map_done  <= 1'b1;
                    end else begin
                        scan_addr <= scan_addr + 1'b1;
                    end
                end
                S_READY: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                    end
                end
                S_ACCESS: begin
                    resp_rdata <= lat_we ? '0 : rd_data;
                    resp_err   <= unrep_map[lat_addr];
                    if (lat_we && hit)
                        spare_data[hit_idx] <= lat_wdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flip_patch_ctrl.sv
// Self-checking bench for flip_patch_ctrl: behavioural RAM/map, reference model of
// the logical memory contents, directed and randomized scenarios.
module tb_flip_patch_ctrl;
    localparam int N_WORDS  = 64;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 6;
    localparam int N_SPARES = 4;
    localparam int SU_W     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] err_addr;
    logic [1:0]        err_data;
    logic              map_done;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [SU_W-1:0]   spares_used;
    logic              overflow;

    int checks = 0;
    int passed = 0;

    logic [1:0]        map_mem   [N_WORDS];
    logic [DATA_W-1:0] ram       [N_WORDS];
    logic [DATA_W-1:0] load_data [N_WORDS];
    logic              load_req = 1'b0;

    // Reference model: role 0 healthy, 1 flip, 2 spare-backed, 3 unrepairable
    int                role    [N_WORDS];
    logic [DATA_W-1:0] logical [N_WORDS];
    int                exp_spares;
    logic              exp_ovf;

    flip_patch_ctrl #(.N_WORDS(N_WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SPARES(N_SPARES)) dut (
        .clk(clk), .reset(reset), .start(start), .err_addr(err_addr), .err_data(err_data),
        .map_done(map_done), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .spares_used(spares_used), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign err_data  = map_mem[err_addr];
    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (load_req) ram <= load_data;
        else if (mem_write_enable) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [62:0] all_outs();
        return {err_addr, map_done, req_ready, resp_valid, resp_rdata, resp_err,
                mem_write_enable, mem_addr, mem_wdata, spares_used, overflow};
    endfunction

    function automatic void build_model();
        int used = 0;
        exp_ovf = 1'b0;
        for (int a = 0; a < N_WORDS; a++) begin
            if (map_mem[a] == 2'b00) begin
                role[a] = 0; logical[a] = ram[a];
            end else if (map_mem[a] == 2'b01) begin
                role[a] = 1; logical[a] = ~ram[a];
            end else if (used < N_SPARES) begin
                role[a] = 2; logical[a] = '0; used++;
            end else begin
                role[a] = 3; logical[a] = ram[a]; exp_ovf = 1'b1;
            end
        end
        exp_spares = used;
    endfunction

    task automatic load_ram_random();
        for (int a = 0; a < N_WORDS; a++) load_data[a] = DATA_W'($urandom);
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic run_scan(output int edges, output bit addr_ok);
        edges = 0; addr_ok = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (edges < 200) begin
            @(negedge clk);
            if (map_done) break;
            if (err_addr !== ADDR_W'(edges)) addr_ok = 1'b0;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic do_req(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output logic [DATA_W-1:0] rd, output logic er, output logic strobe,
                          output bit to);
        int n = 0;
        to = 1'b0; rd = '0; er = 1'b0; strobe = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin to = 1'b1; return; end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        strobe = mem_write_enable;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 5);
        if (!resp_valid) to = 1'b1;
        rd = resp_rdata; er = resp_err;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h expected 0", all_outs());
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_healthy();
        int edges; bit aok; logic [DATA_W-1:0] rd; logic er, st; bit to;
        for (int a = 0; a < N_WORDS; a++) map_mem[a] = 2'b00;
        load_ram_random();
        run_scan(edges, aok);
        build_model();
        checks++; if (edges !== 64) $display("FAIL healthy_done_latency: got %0d expected 64", edges); else passed++;
        checks++; if (aok !== 1'b1) $display("FAIL healthy_scan_addr: got %0d expected 1", aok); else passed++;
        checks++; if ({spares_used, overflow} !== 4'b0) $display("FAIL healthy_tables: got %h expected 0", {spares_used, overflow}); else passed++;
        checks++; if ({err_addr, req_ready} !== 7'b1) $display("FAIL healthy_ready: got %h expected 1", {err_addr, req_ready}); else passed++;
        do_req(1'b1, 6'd5, 16'h1234, rd, er, st, to);
        checks++; if ({to, st, rd, er} !== {1'b0, 1'b1, 16'h0, 1'b0}) $display("FAIL healthy_write: got %h expected %h", {to, st, rd, er}, {1'b0, 1'b1, 16'h0, 1'b0}); else passed++;
        checks++; if (ram[5] !== 16'h1234) $display("FAIL healthy_ram: got %h expected 1234", ram[5]); else passed++;
        do_req(1'b0, 6'd5, 16'h0, rd, er, st, to);
        checks++; if ({to, rd, er} !== {1'b0, 16'h1234, 1'b0}) $display("FAIL healthy_read: got %h expected %h", {to, rd, er}, {1'b0, 16'h1234, 1'b0}); else passed++;
    endtask

    task automatic test_flip_patch();
        int edges; bit aok; logic [DATA_W-1:0] rd, old7; logic er, st; bit to;
        do_reset();
        for (int a = 0; a < N_WORDS; a++) map_mem[a] = 2'b00;
        map_mem[3] = 2'b01; map_mem[7] = 2'b10; map_mem[9] = 2'b11;
        load_ram_random();
        run_scan(edges, aok);
        build_model();
        checks++; if ({spares_used, overflow} !== {3'd2, 1'b0}) $display("FAIL mix_tables: got %h expected %h", {spares_used, overflow}, {3'd2, 1'b0}); else passed++;
        do_req(1'b1, 6'd3, 16'h00FF, rd, er, st, to);
        checks++; if (ram[3] !== 16'hFF00) $display("FAIL flip_ram: got %h expected ff00", ram[3]); else passed++;
        do_req(1'b0, 6'd3, 16'h0, rd, er, st, to);
        checks++; if ({to, rd} !== {1'b0, 16'h00FF}) $display("FAIL flip_read: got %h expected 000ff", {to, rd}); else passed++;
        old7 = ram[7];
        do_req(1'b1, 6'd7, 16'hBEEF, rd, er, st, to);
        checks++; if ({to, st} !== 2'b00) $display("FAIL patch_no_strobe: got %b expected 00", {to, st}); else passed++;
        checks++; if (ram[7] !== old7) $display("FAIL patch_ram_untouched: got %h expected %h", ram[7], old7); else passed++;
        do_req(1'b0, 6'd7, 16'h0, rd, er, st, to);
        checks++; if ({to, rd} !== {1'b0, 16'hBEEF}) $display("FAIL patch_read: got %h expected 0beef", {to, rd}); else passed++;
        do_req(1'b0, 6'd9, 16'h0, rd, er, st, to);
        checks++; if ({to, rd} !== 17'h0) $display("FAIL patch_fresh_spare: got %h expected 0", {to, rd}); else passed++;
    endtask

    task automatic test_overflow();
        int edges; bit aok; logic [DATA_W-1:0] rd; logic er, st; bit to;
        do_reset();
        for (int a = 0; a < N_WORDS; a++) map_mem[a] = (a >= 1 && a <= 6) ? 2'b10 : 2'b00;
        load_ram_random();
        run_scan(edges, aok);
        build_model();
        checks++; if ({spares_used, overflow} !== {3'd4, 1'b1}) $display("FAIL ovf_tables: got %h expected %h", {spares_used, overflow}, {3'd4, 1'b1}); else passed++;
        do_req(1'b0, 6'd6, 16'h0, rd, er, st, to);
        checks++; if ({to, rd, er} !== {1'b0, ram[6], 1'b1}) $display("FAIL ovf_read6: got %h expected %h", {to, rd, er}, {1'b0, ram[6], 1'b1}); else passed++;
        do_req(1'b0, 6'd4, 16'h0, rd, er, st, to);
        checks++; if ({to, rd, er} !== {1'b0, 16'h0, 1'b0}) $display("FAIL ovf_read4: got %h expected 0", {to, rd, er}); else passed++;
    endtask

    task automatic test_random();
        int edges; bit aok; logic [DATA_W-1:0] rd, d, exp_ram; logic er, st; bit to, we;
        logic [ADDR_W-1:0] a;
        do_reset();
        for (int i = 0; i < N_WORDS; i++) begin
            int r = $urandom_range(0, 9);
            map_mem[i] = (r <= 5) ? 2'b00 : (r <= 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
        end
        load_ram_random();
        run_scan(edges, aok);
        build_model();
        checks++; if ({spares_used, overflow} !== {SU_W'(exp_spares), exp_ovf}) $display("FAIL rnd_tables: got %h expected %h", {spares_used, overflow}, {SU_W'(exp_spares), exp_ovf}); else passed++;
        for (int k = 0; k < 40; k++) begin
            we = $urandom_range(0, 1); a = ADDR_W'($urandom); d = DATA_W'($urandom);
            do_req(we, a, d, rd, er, st, to);
            checks++;
            if (to) $display("FAIL rnd_timeout: got timeout expected response at addr %0d", a);
            else if (er !== (role[a] == 3)) $display("FAIL rnd_err: got %b expected %b addr %0d", er, role[a] == 3, a);
            else if (we && (rd !== '0 || st !== (role[a] != 2))) $display("FAIL rnd_write: got rd %h strobe %b expected 0 %b", rd, st, role[a] != 2);
            else if (!we && rd !== logical[a]) $display("FAIL rnd_read: got %h expected %h addr %0d", rd, logical[a], a);
            else passed++;
            if (we) begin
                logical[a] = d;
                if (role[a] != 2) begin
                    exp_ram = (role[a] == 1) ? ~d : d;
                    checks++; if (ram[a] !== exp_ram) $display("FAIL rnd_ram: got %h expected %h addr %0d", ram[a], exp_ram, a); else passed++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] q_rd[$]; logic q_er[$];
        int accepts = 0, resps = 0, last_acc = -10;
        bit gap_ok = 1'b1, consec = 1'b0, prev_rv = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
        for (int cyc = 0; cyc < 23; cyc++) begin
            if (cyc == 20) req_valid = 1'b0;
            if (resp_valid) begin
                if (prev_rv) consec = 1'b1;
                resps++;
                checks++;
                if (q_rd.size() == 0) $display("FAIL b2b_extra_resp: got response expected none");
                else begin
                    logic [DATA_W-1:0] e_rd = q_rd.pop_front();
                    logic e_er = q_er.pop_front();
                    if ({resp_rdata, resp_err} !== {e_rd, e_er}) $display("FAIL b2b_resp: got %h expected %h", {resp_rdata, resp_err}, {e_rd, e_er});
                    else passed++;
                end
            end
            prev_rv = resp_valid;
            if (req_ready && req_valid) begin
                if (last_acc >= 0 && cyc - last_acc != 2) gap_ok = 1'b0;
                last_acc = cyc; accepts++;
                q_er.push_back(role[req_addr] == 3);
                if (req_we) begin q_rd.push_back('0); logical[req_addr] = req_wdata; end
                else q_rd.push_back(logical[req_addr]);
            end else if (!req_ready) begin
                req_we = ~req_we; req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
            end
            @(negedge clk);
        end
        checks++; if (accepts !== 10) $display("FAIL b2b_accepts: got %0d expected 10", accepts); else passed++;
        checks++; if (resps !== accepts) $display("FAIL b2b_resp_count: got %0d expected %0d", resps, accepts); else passed++;
        checks++; if ({gap_ok, consec} !== 2'b10) $display("FAIL b2b_spacing: got %b expected 10", {gap_ok, consec}); else passed++;
    endtask

    task automatic test_reset_mid();
        int edges; bit aok; logic [DATA_W-1:0] rd, old; logic er, st; bit to;
        logic [ADDR_W-1:0] pa;
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 checks++;
        if (all_outs() !== '0) $display("FAIL reset_mid_scan: got %h expected 0", all_outs()); else passed++;
        @(negedge clk); reset = 1'b0;
        for (int a = 0; a < N_WORDS; a++) map_mem[a] = 2'b00;
        pa = ADDR_W'($urandom_range(0, N_WORDS - 1));
        map_mem[pa] = 2'b11;
        run_scan(edges, aok);
        build_model();
        checks++; if ({edges, aok, spares_used} !== {32'd64, 1'b1, 3'd1}) $display("FAIL rescan: got %0d %b %0d expected 64 1 1", edges, aok, spares_used); else passed++;
        do_req(1'b1, pa, 16'hA5A5, rd, er, st, to);
        pa = pa ^ 6'd1;
        old = ram[pa];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = pa; req_wdata = ~old;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_write_enable !== 1'b1) $display("FAIL access_strobe: got %b expected 1", mem_write_enable); else passed++;
        #1 reset = 1'b1;
        #1 checks++;
        if (all_outs() !== '0) $display("FAIL reset_mid_access: got %h expected 0", all_outs()); else passed++;
        @(negedge clk);
        checks++; if (ram[pa] !== old) $display("FAIL reset_abort_write: got %h expected %h", ram[pa], old); else passed++;
        reset = 1'b0;
        run_scan(edges, aok);
        build_model();
        pa = pa ^ 6'd1;
        do_req(1'b0, pa, 16'h0, rd, er, st, to);
        checks++; if ({to, rd} !== 17'h0) $display("FAIL spare_cleared: got %h expected 0", {to, rd}); else passed++;
    endtask

    initial begin
        for (int a = 0; a < N_WORDS; a++) begin map_mem[a] = 2'b00; load_data[a] = '0; end
        test_reset();
        test_healthy();
        test_flip_patch();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/flip_patch_ctrl.md
Name: flip_patch_ctrl

Overview:
Consumer of the per-word fault classification map produced after the 1s/0s sweeps. On start it scans the 2-bit map once and builds two tables: a flip bitmap and a spare-word patch table. It then serves user read/write requests to the faulty RAM, storing flip-class words inverted and redirecting patch-class words to internal spare registers.

Parameters:
N_WORDS, 64, RAM depth in words
DATA_W, 16, word width
ADDR_W, $clog2(N_WORDS), address width
N_SPARES, 4, number of spare word registers (patch table entries)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin map scan; sampled only in IDLE
err_addr  out  ADDR_W  map read address
err_data  in  2  map code at err_addr, combinational, same cycle
map_done  out  1  tables built, sticky until reset
req_valid  in  1  user request valid
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  user word address
req_wdata  in  DATA_W  user write data
resp_valid  out  1  one-cycle response pulse, reads and writes
resp_rdata  out  DATA_W  corrected read data, 0 for writes
resp_err  out  1  accessed word is unrepairable
mem_write_enable  out  1  RAM write strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, combinational on mem_addr
spares_used  out  $clog2(N_SPARES+1)  allocated patch entries
overflow  out  1  at least one patch-class word found no spare, sticky

Behaviour:
- Map codes: 00 = healthy; 01 = flip (store ~data); 10 and 11 = patch (spare register).
- Reset: state IDLE; all outputs 0 (err_addr 0, map_done 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_* 0, spares_used 0, overflow 0); flip bitmap, patch valid bits, spares and unrepairable bitmap all cleared. Reset is asynchronous and aborts any scan or access in progress.
- FSM IDLE -> SCAN on start. start is ignored in every other state.
- SCAN lasts N_WORDS cycles; err_addr = 0..N_WORDS-1, one per cycle. Each cycle, err_data is captured for that address:
  - 01: set flip bit.
  - 1x with spares_used < N_SPARES: allocate next entry in ascending order (valid, addr; spare data = 0); spares_used++.
  - 1x with no free spare: set unrepairable bit and overflow.
- After address N_WORDS-1: -> READY; map_done = 1 from the first READY cycle.
- READY: req_ready = 1. On req_valid, latch we/addr/wdata -> ACCESS. req_ready = 0 in ACCESS.
- ACCESS, 1 cycle; patch hit = valid entry with matching addr:
  - Write, hit: spare <= wdata; RAM untouched.
  - Write, flip: mem_write_enable = 1, mem_wdata = ~wdata.
  - Write, otherwise: mem_write_enable = 1, mem_wdata = wdata.
  - Read: mem_addr = latched addr. Data = spare on hit, else ~mem_rdata if flip bit set, else mem_rdata.
  - Data registered to resp_rdata at the ACCESS->READY edge. resp_valid pulses in the following READY cycle.
  - resp_err = unrepairable bit of the address. That access still uses the RAM path, with no flip.
- Throughput: one request per 2 cycles. Read latency from acceptance edge to resp_valid is 2 edges.
- mem_write_enable = 0 and mem_addr = 0 outside ACCESS (mem_addr = latched addr during ACCESS).
- Flip and patch never both apply: a patch code never sets a flip bit.
- No wrap-around. The scan stops at N_WORDS-1; err_addr holds 0 in READY.

Test Plan:
- All-00 map, N_WORDS = 64: start -> map_done asserts 64 cycles after the SCAN entry edge, spares_used = 0, overflow = 0. Write 0x1234 to addr 5, then read addr 5 -> resp_rdata = 0x1234; RAM[5] = 0x1234.
- Map code 01 at addr 3: write 0x00FF to 3 -> RAM[3] = 0xFF00; read 3 -> resp_rdata = 0x00FF.
- Map code 10 at 7 and 11 at 9: spares_used = 2. Write 0xBEEF to 7 -> no RAM write strobe; read 7 -> 0xBEEF.
- Map code 10 at 6 addresses {1,2,3,4,5,6} with N_SPARES = 4: spares_used = 4, overflow = 1. Read 6 -> resp_err = 1; read 4 -> resp_err = 0.
- req_valid held continuously, alternating we: accepted every other cycle; resp_valid once per request, never 2 consecutive cycles.
- Reset asserted mid-SCAN, and again during ACCESS: outputs return to 0 immediately. A following start rescans from addr 0 and rebuilds tables.
